udp_mc_sender: RTL and testbench

Multi-channel UDP/IPv4 frame generator, successor to the single-channel sender. It arbitrates round-robin between NCH channel buffers and builds a complete Ethernet/IPv4/UDP frame for each granted request. The frame streams as 32-bit words onto the MAC TX FIFO interface (sop/eop/mod/wren/rdy). It sits between the per-channel capture RAMs and the Ethernet MAC transmit port.

---
 rtl/udp_mc_sender.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_udp_mc_sender.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_mc_sender.sv
// -----------------------------------------------------------------------------
// udp_mc_sender
// Multi-channel UDP/IPv4 frame generator. Channel requests are queued as
// pending bits and served round-robin. Each granted request produces one
// Ethernet/IPv4/UDP frame: 12 header words followed by ceil(L/4) payload
// words read from that channel's buffer. Words go out on a 32-bit MAC TX
// FIFO interface.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req[NCH]          per-channel request pulse
//   len[16*NCH]       payload byte count per channel (sampled with req)
//   mac, dest_mac     source / destination MAC
//   ip_source/ip_dest source / destination IPv4 address
//   port_source       UDP source port
//   port_dest_base    UDP destination port of channel 0 (channel c adds c)
//   time_buf          timestamp placed in header word 11
//   mem_adr_rd        {channel, word index} read address of the buffers
//   mem_data          registered RAM data, one cycle after the address
//   tx_*              MAC FIFO write side; tx_rdy is the FIFO ready
//   busy              frame in progress
//   done, done_chan   one-cycle pulse after the last word, and its channel
//   ovf[NCH]          sticky per-channel overrun flags
// -----------------------------------------------------------------------------
module udp_mc_sender #(
   parameter int NCH     = 4,
   parameter int WAW     = 9,
   parameter int MAX_LEN = 1472,
   parameter int TTL     = 64,
   localparam int CW     = $clog2(NCH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NCH-1:0]        req,
   input  logic [16*NCH-1:0]     len,
   input  logic [47:0]           mac,
   input  logic [47:0]           dest_mac,
   input  logic [31:0]           ip_source,
   input  logic [31:0]           ip_dest,
   input  logic [15:0]           port_source,
   input  logic [15:0]           port_dest_base,
   input  logic [31:0]           time_buf,
   output logic [CW+WAW-1:0]     mem_adr_rd,
   input  logic [31:0]           mem_data,
   output logic [31:0]           tx_data,
   output logic                  tx_sop,
   output logic                  tx_eop,
   output logic                  tx_wren,
   output logic [1:0]            tx_mod,
   output logic                  tx_err,
   input  logic                  tx_rdy,
   output logic                  busy,
   output logic                  done,
   output logic [CW-1:0]         done_chan,
   output logic [NCH-1:0]        ovf
);

   localparam logic [7:0] TTL8 = 8'(TTL);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARB  = 3'd1,
      S_HDR  = 3'd2,
      S_DATA = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // IPv4 header checksum over the ten header words (checksum field as 0).
   // Ten 16-bit words fit in 20 bits; two folds absorb every carry.
   function automatic logic [15:0] ip_hcs(input logic [15:0] tl,
                                          input logic [15:0] id,
                                          input logic [31:0] ips,
                                          input logic [31:0] ipd);
      logic [19:0] s;
      s = 20'h04500 + {4'd0, tl} + {4'd0, id} + {4'd0, TTL8, 8'h11}
        + {4'd0, ips[31:16]} + {4'd0, ips[15:0]}
        + {4'd0, ipd[31:16]} + {4'd0, ipd[15:0]};
      s = {4'd0, s[15:0]} + {16'd0, s[19:16]};
      s = {4'd0, s[15:0]} + {16'd0, s[19:16]};
      return ~s[15:0];
   endfunction

   state_t          r_state, w_state_nx;
   logic [NCH-1:0]  r_pend;
   logic [15:0]     r_plen [NCH];
   logic [NCH-1:0]  r_ovf;
   logic [CW-1:0]   r_last;
   logic [CW-1:0]   r_chan;
   logic [15:0]     r_len;
   logic [15:0]     r_ident;
   logic [47:0]     r_dmac, r_smac;
   logic [31:0]     r_ips, r_ipd, r_time;
   logic [15:0]     r_sport, r_dport;
   logic [3:0]      r_widx;
   logic [WAW-1:0]  r_didx;
   logic [31:0]     r_tx_data;
   logic            r_sop, r_eop, r_wren, r_busy, r_done;
   logic [1:0]      r_mod;
   logic [CW-1:0]   r_done_chan;

   logic            w_gnt_any;
   logic [CW-1:0]   w_gnt;
   logic            w_send, w_eop, w_active;
   logic [31:0]     w_hdr, w_word;
   logic [15:0]     w_total_len, w_udp_len, w_hcs, w_last_idx;
   logic [1:0]      w_mod;
   logic [WAW-1:0]  w_rd_idx;

   assign w_total_len = 16'd34 + r_len;
   assign w_udp_len   = 16'd14 + r_len;
   assign w_hcs       = ip_hcs(w_total_len, r_ident, r_ips, r_ipd);
   assign w_last_idx  = ((r_len + 16'd3) >> 2) - 16'd1;
   assign w_mod       = 2'(3'd4 - {1'b0, r_len[1:0]});
   assign w_active    = (r_state == S_ARB) || (r_state == S_HDR) || (r_state == S_DATA);

   // The RAM has no read enable, so the address must be chosen in the same
   // cycle the word is consumed: advance only when a data word actually
   // leaves this cycle, otherwise re-read the unsent word so mem_data holds.
   assign w_rd_idx   = ((r_state == S_DATA) && tx_rdy) ? r_didx + WAW'(1) : r_didx;
   assign mem_adr_rd = {r_chan, w_rd_idx};

   assign tx_data   = r_tx_data;
   assign tx_sop    = r_sop;
   assign tx_eop    = r_eop;
   assign tx_wren   = r_wren;
   assign tx_mod    = r_mod;
   assign tx_err    = 1'b0;
   assign busy      = r_busy;
   assign done      = r_done;
   assign done_chan = r_done_chan;
   assign ovf       = r_ovf;

   // Round-robin pick: scan downwards so the nearest set bit after r_last wins.
   always_comb begin
      w_gnt_any = |r_pend;
      w_gnt     = r_last;
      for (int i = NCH; i >= 1; i--) begin
         w_gnt = r_pend[(int'(r_last) + i) % NCH] ? CW'((int'(r_last) + i) % NCH) : w_gnt;
      end
   end

   // Header word selection by word index (W0 is sent from ARB with index 0).
   always_comb begin
      w_hdr = 32'd0;
      case (r_widx)
         4'd0:    w_hdr = r_dmac[47:16];
         4'd1:    w_hdr = {r_dmac[15:0], r_smac[47:32]};
         4'd2:    w_hdr = r_smac[31:0];
         4'd3:    w_hdr = {16'h0800, 8'h45, 8'h00};
         4'd4:    w_hdr = {w_total_len, r_ident};
         4'd5:    w_hdr = {16'h0000, TTL8, 8'h11};
         4'd6:    w_hdr = {w_hcs, r_ips[31:16]};
         4'd7:    w_hdr = {r_ips[15:0], r_ipd[31:16]};
         4'd8:    w_hdr = {r_ipd[15:0], r_sport};
         4'd9:    w_hdr = {r_dport, w_udp_len};
         4'd10:   w_hdr = {24'd0, 8'(r_chan)};
         4'd11:   w_hdr = r_time;
         default: w_hdr = 32'd0;
      endcase
   end

   // Next-state logic; every transmit state only advances on tx_rdy.
   always_comb begin
      w_state_nx = r_state;
      w_send     = 1'b0;
      w_eop      = 1'b0;
      w_word     = w_hdr;
      case (r_state)
         S_IDLE: begin
            if (w_gnt_any) w_state_nx = S_ARB;
            else           w_state_nx = S_IDLE;
         end
         S_ARB: begin
            w_send = tx_rdy;
            if (tx_rdy) w_state_nx = S_HDR;
            else        w_state_nx = S_ARB;
         end
         S_HDR: begin
            w_send = tx_rdy;
            w_eop  = (r_widx == 4'd11) && (r_len == 16'd0);
            if (tx_rdy && (r_widx == 4'd11)) begin
               if (r_len == 16'd0) w_state_nx = S_DONE;
               else                w_state_nx = S_DATA;
            end else begin
               w_state_nx = S_HDR;
            end
         end
         S_DATA: begin
            w_send = tx_rdy;
            w_word = mem_data;
            w_eop  = (16'(r_didx) == w_last_idx);
            if (tx_rdy && w_eop) w_state_nx = S_DONE;
            else                 w_state_nx = S_DATA;
         end
         S_DONE: begin
            w_state_nx = S_IDLE;
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nx;
   end

   // Pending/overrun bookkeeping, grant latching and the transmit datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend      <= '0;
         r_ovf       <= '0;
         r_last      <= CW'(NCH - 1);
         r_chan      <= '0;
         r_len       <= 16'd0;
         r_ident     <= 16'd0;
         r_dmac      <= 48'd0;
         r_smac      <= 48'd0;
         r_ips       <= 32'd0;
         r_ipd       <= 32'd0;
         r_time      <= 32'd0;
         r_sport     <= 16'd0;
         r_dport     <= 16'd0;
         r_widx      <= 4'd0;
         r_didx      <= '0;
         r_tx_data   <= 32'd0;
         r_sop       <= 1'b0;
         r_eop       <= 1'b0;
         r_wren      <= 1'b0;
         r_mod       <= 2'd0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_done_chan <= '0;
         for (int c = 0; c < NCH; c++) r_plen[c] <= 16'd0;
      end else begin
         // A req for a channel already pending or on the wire is an overrun.
         for (int c = 0; c < NCH; c++) begin
            if ((r_state == S_IDLE) && w_gnt_any && (w_gnt == CW'(c))) r_pend[c] <= 1'b0;
            if (req[c] && (r_pend[c] || (w_active && (r_chan == CW'(c))))) begin
               r_ovf[c] <= 1'b1;
            end else if (req[c]) begin
               r_pend[c] <= 1'b1;
               r_plen[c] <= (len[16*c +: 16] > 16'(MAX_LEN)) ? 16'(MAX_LEN) : len[16*c +: 16];
            end
         end

         if ((r_state == S_IDLE) && w_gnt_any) begin
            r_chan  <= w_gnt;
            r_last  <= w_gnt;
            r_len   <= r_plen[w_gnt];
            r_dmac  <= dest_mac;
            r_smac  <= mac;
            r_ips   <= ip_source;
            r_ipd   <= ip_dest;
            r_time  <= time_buf;
            r_sport <= port_source;
            r_dport <= port_dest_base + 16'(w_gnt);
            r_widx  <= 4'd0;
            r_didx  <= '0;
         end

         if (w_send) begin
            r_tx_data <= w_word;
            r_wren    <= 1'b1;
            r_sop     <= (r_state == S_ARB);
            r_eop     <= w_eop;
            r_mod     <= w_eop ? w_mod : 2'd0;
            if (r_state == S_DATA) r_didx <= r_didx + WAW'(1);
            else                   r_widx <= r_widx + 4'd1;
         end else begin
            r_wren <= 1'b0;
            r_sop  <= 1'b0;
            r_eop  <= 1'b0;
            r_mod  <= 2'd0;
         end

         r_done <= (r_state == S_DONE);
         if (r_state == S_DONE) begin
            r_done_chan <= r_chan;
            r_ident     <= r_ident + 16'd1;
         end
         r_busy <= (w_state_nx != S_IDLE);
      end
   end

endmodule

// File: tb/tb_udp_mc_sender.sv
// -----------------------------------------------------------------------------
// tb_udp_mc_sender
// Directed bench for udp_mc_sender: a table of single-frame vectors with
// hand-computed word counts, tx_mod and total_len, followed by hand-written
// sequences for arbitration order, back-pressure, overrun and mid-frame reset.
// A word-level model of the frame supplies every expected data word.
// -----------------------------------------------------------------------------
module tb_udp_mc_sender;

   localparam int NCH = 4;
   localparam int WAW = 9;
   localparam int CW  = 2;

   localparam logic [47:0] SMAC  = 48'h0011_2233_4455;
   localparam logic [47:0] DMAC  = 48'hFFEE_DDCC_BBAA;
   localparam logic [31:0] IPS   = 32'hC0A8_0001;
   localparam logic [31:0] IPD   = 32'hC0A8_0002;
   localparam logic [15:0] SPORT = 16'h04D2;
   localparam logic [15:0] DBASE = 16'h1388;
   localparam logic [31:0] TSTMP = 32'hDEAD_BEEF;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NCH-1:0]       req;
   logic [16*NCH-1:0]    len;
   logic [CW+WAW-1:0]    mem_adr_rd;
   logic [31:0]          mem_data;
   logic [31:0]          tx_data;
   logic                 tx_sop, tx_eop, tx_wren, tx_err, tx_rdy;
   logic [1:0]           tx_mod;
   logic                 busy, done;
   logic [CW-1:0]        done_chan;
   logic [NCH-1:0]       ovf;
   logic [47:0]          mac_s, dmac_s;
   logic [31:0]          ips_s, ipd_s, time_s;
   logic [15:0]          sport_s, dbase_s;

   assign mac_s   = SMAC;
   assign dmac_s  = DMAC;
   assign ips_s   = IPS;
   assign ipd_s   = IPD;
   assign sport_s = SPORT;
   assign dbase_s = DBASE;
   assign time_s  = TSTMP;

   always #5 clk = ~clk;

   udp_mc_sender #(.NCH(NCH), .WAW(WAW), .MAX_LEN(1472), .TTL(64)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .len(len),
      .mac(mac_s), .dest_mac(dmac_s), .ip_source(ips_s), .ip_dest(ipd_s),
      .port_source(sport_s), .port_dest_base(dbase_s), .time_buf(time_s),
      .mem_adr_rd(mem_adr_rd), .mem_data(mem_data),
      .tx_data(tx_data), .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_wren(tx_wren),
      .tx_mod(tx_mod), .tx_err(tx_err), .tx_rdy(tx_rdy),
      .busy(busy), .done(done), .done_chan(done_chan), .ovf(ovf)
   );

   // Unique, address-derived buffer contents.
   function automatic logic [31:0] pat(input logic [10:0] a);
      return {5'b10101, a, 5'b01010, ~a};
   endfunction

   // Registered RAM: data one cycle after the address.
   always @(posedge clk) mem_data <= pat(mem_adr_rd);

   // Reference IP checksum: plain word loop, fold until no carry remains.
   function automatic logic [15:0] sw_csum(input logic [15:0] tl, input logic [15:0] id);
      logic [15:0] w [10];
      int unsigned s;
      w = '{16'h4500, tl, id, 16'h0000, 16'h4011, 16'h0000,
            IPS[31:16], IPS[15:0], IPD[31:16], IPD[15:0]};
      s = 0;
      foreach (w[k]) s = s + w[k];
      while ((s >> 16) != 0) s = (s & 32'h0000_FFFF) + (s >> 16);
      return ~s[15:0];
   endfunction

   // Expected word i of a frame for channel c, payload L bytes, ident id.
   function automatic logic [31:0] exp_word(input int c, input int L, input logic [15:0] id, input int i);
      logic [15:0] tl, ul, hcs;
      logic [10:0] a;
      tl  = 16'(34 + L);
      ul  = 16'(14 + L);
      hcs = sw_csum(tl, id);
      case (i)
         0:  return DMAC[47:16];
         1:  return {DMAC[15:0], SMAC[47:32]};
         2:  return SMAC[31:0];
         3:  return 32'h0800_4500;
         4:  return {tl, id};
         5:  return 32'h0000_4011;
         6:  return {hcs, IPS[31:16]};
         7:  return {IPS[15:0], IPD[31:16]};
         8:  return {IPD[15:0], SPORT};
         9:  return {16'(DBASE + 16'(c)), ul};
         10: return 32'(c);
         11: return TSTMP;
         default: begin
            a = {2'(c), 9'(i - 12)};
            return pat(a);
         end
      endcase
   endfunction

   typedef struct {
      logic        sop;
      logic        eop;
      logic [1:0]  mod;
      logic [31:0] d;
      int          cyc;
   } wrd_t;

   wrd_t cap_q[$];
   wrd_t fr_q[$];
   int   done_ch_q[$];
   int   done_cyc_q[$];
   int   cyc  = 0;
   int   viol = 0;
   logic rdy_q = 1'b0;
   logic rnd_rdy = 1'b0;
   int   errs = 0;
   int   checks = 0;
   int   req_cyc;

   always @(posedge clk) rdy_q <= tx_rdy;

   // Output monitor, sampling on the falling edge.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (tx_wren) begin
         if (!rdy_q) viol <= viol + 1;
         cap_q.push_back('{tx_sop, tx_eop, tx_mod, tx_data, cyc + 1});
      end
      if (done) begin
         done_ch_q.push_back(int'(done_chan));
         done_cyc_q.push_back(cyc + 1);
      end
   end

   // tx_rdy driver: held high, or random 50% when rnd_rdy is set.
   initial begin
      tx_rdy = 1'b1;
      forever begin
         @(negedge clk);
         tx_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({tx_data, tx_sop, tx_eop, tx_wren, tx_mod, tx_err,
                  busy, done, done_chan, ovf, mem_adr_rd});
   endfunction

   task automatic send_req(input int c, input int L);
      @(negedge clk); #1;
      req = 4'(1 << c);
      len[16*c +: 16] = 16'(L);
      req_cyc = cyc;
      @(negedge clk); #1;
      req = '0;
   endtask

   // Waits for one done pulse, pulls that frame from the capture queue and
   // compares it against the model.
   task automatic check_frame(input int c, input int L, input logic [15:0] id, input int rc,
                              input int exp_nw, input logic [1:0] exp_mod, input string tag);
      int k, nw, bad, fbad, first;
      wrd_t w;
      k = 0;
      while (done_ch_q.size() == 0 && k < 4000) begin
         @(negedge clk); #1;
         k++;
      end
      if (done_ch_q.size() == 0) begin
         checks++;
         errs++;
         $display("FAIL %s_timeout: got no done pulse expected one within 4000 cycles", tag);
         return;
      end
      chk({tag, "_done_chan"}, 64'(done_ch_q[0]), 64'(c));
      fr_q.delete();
      while (cap_q.size() > 0) begin
         w = cap_q.pop_front();
         fr_q.push_back(w);
         if (w.eop) break;
      end
      nw = fr_q.size();
      chk({tag, "_words"}, 64'(nw), 64'(exp_nw));
      bad = 0; fbad = 0; first = -1;
      for (int i = 0; i < nw; i++) begin
         if (fr_q[i].d !== exp_word(c, L, id, i)) begin
            bad++;
            if (first < 0) first = i;
         end
         if (fr_q[i].sop !== (i == 0) || fr_q[i].eop !== (i == nw - 1)) fbad++;
         if (i != nw - 1 && fr_q[i].mod !== 2'd0) fbad++;
      end
      chk($sformatf("%s_content(first_bad_word=%0d)", tag, first), 64'(bad), 64'd0);
      chk({tag, "_sop_eop_flags"}, 64'(fbad), 64'd0);
      if (nw > 0) begin
         chk({tag, "_eop_mod"}, 64'(fr_q[nw-1].mod), 64'(exp_mod));
         chk({tag, "_done_after_eop"}, 64'(done_cyc_q[0] - fr_q[nw-1].cyc), 64'd1);
         if (rc >= 0) chk({tag, "_sop_latency"}, 64'(fr_q[0].cyc - rc), 64'd3);
      end
      void'(done_ch_q.pop_front());
      void'(done_cyc_q.pop_front());
   endtask

   task automatic do_reset();
      @(negedge clk); #1;
      rst_n = 1'b0;
      req   = '0;
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      cap_q.delete();
      done_ch_q.delete();
      done_cyc_q.delete();
   endtask

   typedef struct {
      int          ch;
      int          len;
      int          nw;
      logic [1:0]  md;
      logic [15:0] tl;
   } vec_t;

   initial begin
      vec_t vt [7];
      int   ident;
      int   eff;
      int   k;

      vt[0] = '{0,   32, 20,  2'd0, 16'd66};
      vt[1] = '{2,    1, 13,  2'd3, 16'd35};
      vt[2] = '{2,    2, 13,  2'd2, 16'd36};
      vt[3] = '{2,    3, 13,  2'd1, 16'd37};
      vt[4] = '{2,    5, 14,  2'd3, 16'd39};
      vt[5] = '{1,    0, 12,  2'd0, 16'd34};
      vt[6] = '{3, 2000, 380, 2'd0, 16'd1506};

      rst_n = 1'b0;
      req   = '0;
      len   = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_outputs", all_outs(), 64'd0);
      rst_n = 1'b1;
      cap_q.delete();

      // Single frames, tx_rdy high.
      ident = 0;
      for (int i = 0; i < 7; i++) begin
         eff = (vt[i].len > 1472) ? 1472 : vt[i].len;
         send_req(vt[i].ch, vt[i].len);
         check_frame(vt[i].ch, eff, 16'(ident), req_cyc, vt[i].nw, vt[i].md, $sformatf("vec%0d", i));
         if (fr_q.size() > 10) begin
            chk($sformatf("vec%0d_total_len", i), 64'(fr_q[4].d[31:16]), 64'(vt[i].tl));
            chk($sformatf("vec%0d_w10_chan", i), 64'(fr_q[10].d), 64'(vt[i].ch));
         end
         if (i == 0 && fr_q.size() > 9) begin
            chk("vec0_w4", 64'(fr_q[4].d), 64'h0042_0000);
            chk("vec0_w6_hcs", 64'(fr_q[6].d), 64'hF957_C0A8);
            chk("vec0_w9_port", 64'(fr_q[9].d), 64'h1388_002E);
         end
         ident++;
      end
      chk("no_ovf_yet", 64'(ovf), 64'd0);

      // All channels requested together, then ch0+ch1 together.
      do_reset();
      @(negedge clk); #1;
      len = {16'd16, 16'd12, 16'd8, 16'd4};
      req = 4'hF;
      @(negedge clk); #1;
      req = '0;
      for (int c = 0; c < 4; c++)
         check_frame(c, 4 * (c + 1), 16'(c), -1, 13 + c, 2'd0, $sformatf("rr%0d", c));
      @(negedge clk); #1;
      len = {16'd0, 16'd0, 16'd7, 16'd6};
      req = 4'b0011;
      @(negedge clk); #1;
      req = '0;
      check_frame(0, 6, 16'd4, -1, 14, 2'd2, "pair_ch0");
      check_frame(1, 7, 16'd5, -1, 14, 2'd1, "pair_ch1");

      // Random back-pressure on an L=100 frame.
      rnd_rdy = 1'b1;
      send_req(1, 100);
      check_frame(1, 100, 16'd6, -1, 37, 2'd0, "stall");
      rnd_rdy = 1'b0;
      chk("wren_after_not_ready", 64'(viol), 64'd0);

      // Overrun: second req[1] while ch1 waits behind a ch0 frame.
      send_req(0, 100);
      @(negedge clk); #1;
      len[31:16] = 16'd2000;
      req = 4'b0010;
      @(negedge clk); #1;
      req = 4'b0010;
      @(negedge clk); #1;
      req = '0;
      check_frame(0, 100, 16'd7, -1, 37, 2'd0, "ovf_ch0");
      check_frame(1, 1472, 16'd8, -1, 380, 2'd0, "ovf_ch1");
      if (fr_q.size() > 4) chk("clamp_total_len", 64'(fr_q[4].d[31:16]), 64'd1506);
      chk("ovf_flags", 64'(ovf), 64'h2);
      repeat (40) @(negedge clk);
      #1;
      chk("single_ch1_frame", 64'(done_ch_q.size() + cap_q.size()), 64'd0);

      // Reset while W15 is on the bus.
      send_req(0, 32);
      k = 0;
      while (cap_q.size() < 16 && k < 200) begin
         @(negedge clk); #1;
         k++;
      end
      if (cap_q.size() < 16) begin
         checks++;
         errs++;
         $display("FAIL midreset_wait: got %0d words expected 16", cap_q.size());
      end
      rst_n = 1'b0;
      #1;
      chk("midreset_outputs", all_outs(), 64'd0);
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      cap_q.delete();
      done_ch_q.delete();
      done_cyc_q.delete();
      send_req(2, 5);
      check_frame(2, 5, 16'd0, req_cyc, 14, 2'd3, "post_reset");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
